// File: rtl/sseg_capture.sv
// Receive side of a 4-digit multiplexed seven-segment link: debounces the scanned
// anode/segment lines, decodes each digit back to hex and assembles complete frames.
module sseg_capture #(
  parameter int SETTLE = 4,
  parameter int TO_W   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sseg_an,
  input  logic [7:0]  sseg_sig,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        an_fault,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_CAP = CW'(SETTLE - 1);

  logic [3:0]      an_q, an_d;
  logic [7:0]      sig_q, sig_d;
  logic [CW-1:0]   cnt;
  logic [TO_W-1:0] tcnt;
  logic [3:0]      seen;
  logic [15:0]     nib_w;
  logic [3:0]      dp_w, err_w;

  logic        change, capture, single;
  logic [3:0]  sel;
  logic [3:0]  dec_nib;
  logic        dec_err;
  logic [15:0] nib_n;
  logic [3:0]  dp_n, err_n, seen_n;
  logic        frame_done;

  // Active-low segment pattern back to a nibble; unknown patterns decode as 0 and flag.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b0, 4'h0};
      7'h79:   r = {1'b0, 4'h1};
      7'h24:   r = {1'b0, 4'h2};
      7'h30:   r = {1'b0, 4'h3};
      7'h19:   r = {1'b0, 4'h4};
      7'h12:   r = {1'b0, 4'h5};
      7'h02:   r = {1'b0, 4'h6};
      7'h78:   r = {1'b0, 4'h7};
      7'h00:   r = {1'b0, 4'h8};
      7'h10:   r = {1'b0, 4'h9};
      7'h08:   r = {1'b0, 4'hA};
      7'h03:   r = {1'b0, 4'hB};
      7'h46:   r = {1'b0, 4'hC};
      7'h21:   r = {1'b0, 4'hD};
      7'h06:   r = {1'b0, 4'hE};
      7'h0E:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  assign change  = {an_q, sig_q} != {an_d, sig_d};
  assign capture = !change && (cnt == CNT_CAP);
  assign sel     = ~an_q;
  assign single  = $onehot(sel);
  assign {dec_err, dec_nib} = decode(sig_q[6:0]);

  // Working frame as it would look after this edge's capture, so completion includes it.
  always_comb begin
    nib_n  = nib_w;
    dp_n   = dp_w;
    err_n  = err_w;
    seen_n = seen;
    if (capture && single) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) begin
          nib_n[4*k +: 4] = dec_nib;
          dp_n[k]         = ~sig_q[7];
          err_n[k]        = dec_err;
          seen_n[k]       = 1'b1;
        end
      end
    end
    frame_done = capture && single && (seen_n == 4'hF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= 4'hF;
      an_d        <= 4'hF;
      sig_q       <= 8'hFF;
      sig_d       <= 8'hFF;
      cnt         <= '0;
      tcnt        <= '0;
      seen        <= '0;
      nib_w       <= '0;
      dp_w        <= '0;
      err_w       <= '0;
      digits      <= '0;
      dp          <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      an_fault    <= 1'b0;
      stale       <= 1'b0;
    end else begin
      an_q        <= sseg_an;
      sig_q       <= sseg_sig;
      an_d        <= an_q;
      sig_d       <= sig_q;
      frame_valid <= 1'b0;
      an_fault    <= 1'b0;

      if (change)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      // A stale link drops any partial frame; a capture always revives it.
      if (capture) begin
        tcnt  <= '0;
        stale <= 1'b0;
        if (single) begin
          nib_w <= nib_n;
          dp_w  <= dp_n;
          err_w <= err_n;
          if (frame_done) begin
            digits      <= nib_n;
            dp          <= dp_n;
            err         <= err_n;
            frame_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_n;
          end
        end else begin
          an_fault <= 1'b1;
        end
      end else if (&tcnt) begin
        stale <= 1'b1;
        seen  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: a default instance plus a short-timeout instance
// sharing the same pins and reset.
module tb_sseg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sseg_an  = 4'hF;
  logic [7:0]  sseg_sig = 8'hFF;

  logic [15:0] digits, t_digits;
  logic [3:0]  dp, err, t_dp, t_err;
  logic        frame_valid, an_fault, stale;
  logic        t_frame_valid, t_an_fault, t_stale;

  int n_compared   = 0;
  int n_mismatched = 0;
  int fv_count, af_count, fv_at, t_fv_count;

  always #5 clk = ~clk;

  sseg_capture u_dut (
    .clk(clk), .rst(rst), .sseg_an(sseg_an), .sseg_sig(sseg_sig),
    .digits(digits), .dp(dp), .err(err),
    .frame_valid(frame_valid), .an_fault(an_fault), .stale(stale)
  );

  sseg_capture #(.SETTLE(4), .TO_W(4)) u_dut_to (
    .clk(clk), .rst(rst), .sseg_an(sseg_an), .sseg_sig(sseg_sig),
    .digits(t_digits), .dp(t_dp), .err(t_err),
    .frame_valid(t_frame_valid), .an_fault(t_an_fault), .stale(t_stale)
  );

  task automatic clear_tally();
    fv_count   = 0;
    af_count   = 0;
    fv_at      = 0;
    t_fv_count = 0;
  endtask

  // Hold one (an,sig) pair for ncyc clocks, tallying pulses seen after each edge.
  task automatic drive_digit(input logic [3:0] an, input logic [7:0] sig, input int ncyc);
    @(negedge clk);
    sseg_an  = an;
    sseg_sig = sig;
    fv_at    = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        fv_count++;
        fv_at = i;
      end
      if (an_fault) af_count++;
      if (t_frame_valid) t_fv_count++;
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst      = 1'b1;
    sseg_an  = 4'hF;
    sseg_sig = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_tally();
  endtask

  task automatic test_reset();
    hold_reset();
    n_compared++;
    if (digits !== 16'h0 || dp !== 4'h0 || err !== 4'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h/%h/%h want 0000/0/0", digits, dp, err);
    end
    n_compared++;
    if (frame_valid !== 1'b0 || an_fault !== 1'b0 || stale !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got fv=%b af=%b st=%b want 0/0/0", frame_valid, an_fault, stale);
    end
    release_reset();
    drive_digit(4'hF, 8'hFF, 50);
    n_compared++;
    if (fv_count !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_frames: got %0d want 0", fv_count);
    end
    n_compared++;
    if (digits !== 16'h0 || stale !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_outputs: got digits=%h stale=%b want 0000/0", digits, stale);
    end
  endtask

  task automatic test_scan();
    hold_reset();
    release_reset();
    drive_digit(4'b0111, 8'hF9, 8);
    drive_digit(4'b1011, 8'hA4, 8);
    drive_digit(4'b1101, 8'hB0, 8);
    drive_digit(4'b1110, 8'h99, 8);
    n_compared++;
    if (fv_count !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL scan_count: got %0d frames want 1", fv_count);
    end
    n_compared++;
    if (fv_at !== 6) begin
      n_mismatched++;
      $display("[TB] FAIL scan_latency: got edge %0d want 6", fv_at);
    end
    n_compared++;
    if (digits !== 16'h1234) begin
      n_mismatched++;
      $display("[TB] FAIL scan_digits: got %h want 1234", digits);
    end
    n_compared++;
    if (err !== 4'h0 || dp !== 4'h0) begin
      n_mismatched++;
      $display("[TB] FAIL scan_flags: got err=%b dp=%b want 0000/0000", err, dp);
    end
  endtask

  task automatic test_short_dwell();
    hold_reset();
    release_reset();
    drive_digit(4'b0111, 8'hF9, 8);
    drive_digit(4'b1011, 8'hA4, 8);
    drive_digit(4'b1101, 8'hB0, 3);
    drive_digit(4'b1110, 8'h99, 8);
    n_compared++;
    if (fv_count !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL short_no_frame: got %0d frames want 0", fv_count);
    end
    drive_digit(4'b1101, 8'hB0, 8);
    n_compared++;
    if (fv_count !== 1 || fv_at !== 6) begin
      n_mismatched++;
      $display("[TB] FAIL short_resume: got %0d frames at %0d want 1 at 6", fv_count, fv_at);
    end
    n_compared++;
    if (digits !== 16'h1234) begin
      n_mismatched++;
      $display("[TB] FAIL short_digits: got %h want 1234", digits);
    end
  endtask

  task automatic test_illegal();
    hold_reset();
    release_reset();
    drive_digit(4'b0111, 8'hF9, 8);
    drive_digit(4'b1011, 8'hA4, 8);
    drive_digit(4'b1101, 8'hFF, 8);
    drive_digit(4'b1110, 8'h40, 8);
    n_compared++;
    if (fv_count !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_count: got %0d frames want 1", fv_count);
    end
    n_compared++;
    if (err !== 4'b0010) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_err: got %b want 0010", err);
    end
    n_compared++;
    if (dp !== 4'b0001) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_dp: got %b want 0001", dp);
    end
    n_compared++;
    if (digits !== 16'h1200) begin
      n_mismatched++;
      $display("[TB] FAIL illegal_digits: got %h want 1200", digits);
    end
  endtask

  task automatic test_an_fault();
    hold_reset();
    release_reset();
    drive_digit(4'b0111, 8'hF9, 8);
    drive_digit(4'b1011, 8'hA4, 8);
    clear_tally();
    drive_digit(4'b1100, 8'hB0, 8);
    n_compared++;
    if (af_count !== 1) begin
      n_mismatched++;
      $display("[TB] FAIL fault_pulses: got %0d want 1", af_count);
    end
    n_compared++;
    if (fv_count !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL fault_no_frame: got %0d frames want 0", fv_count);
    end
    drive_digit(4'b1101, 8'hB0, 8);
    drive_digit(4'b1110, 8'h99, 8);
    n_compared++;
    if (fv_count !== 1 || digits !== 16'h1234) begin
      n_mismatched++;
      $display("[TB] FAIL fault_seen_kept: got %0d frames digits=%h want 1/1234", fv_count, digits);
    end
  endtask

  task automatic test_timeout();
    hold_reset();
    release_reset();
    drive_digit(4'b0111, 8'hF9, 8);
    n_compared++;
    if (t_stale !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_early: got stale=%b want 0", t_stale);
    end
    drive_digit(4'b1011, 8'hA4, 28);
    n_compared++;
    if (t_stale !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_stale: got stale=%b want 1", t_stale);
    end
    drive_digit(4'b1101, 8'hB0, 8);
    n_compared++;
    if (t_stale !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_clear: got stale=%b want 0", t_stale);
    end
    drive_digit(4'b1110, 8'h99, 8);
    n_compared++;
    if (t_fv_count !== 0 || t_digits !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_dropped: got %0d frames digits=%h want 0/0000", t_fv_count, t_digits);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_digit(4'b0111, 8'hF9, 8);
    drive_digit(4'b1011, 8'hA4, 8);
    hold_reset();
    n_compared++;
    if (digits !== 16'h0 || frame_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_clear: got digits=%h fv=%b want 0000/0", digits, frame_valid);
    end
    release_reset();
    drive_digit(4'b1101, 8'hB0, 8);
    drive_digit(4'b1110, 8'h99, 8);
    n_compared++;
    if (fv_count !== 0 || digits !== 16'h0) begin
      n_mismatched++;
      $display("[TB] FAIL midrst_no_frame: got %0d frames digits=%h want 0/0000", fv_count, digits);
    end
  endtask

  initial begin
    clear_tally();
    test_reset();
    test_scan();
    test_short_dwell();
    test_illegal();
    test_an_fault();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
